// File: rtl/apb_cmd_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_bridge_pkg
// Purpose  : Shared types and constants for the command-to-APB bridge:
//            FSM state encodings, the default timeout read-data pattern and
//            the wait-counter width helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package apb_bridge_pkg;

    // Fixed encodings so that existing debug tooling decoding the raw state
    // bits keeps working.
    localparam logic [1:0] C_ST_IDLE   = 2'd0;
    localparam logic [1:0] C_ST_SETUP  = 2'd1;
    localparam logic [1:0] C_ST_ACCESS = 2'd2;
    localparam logic [1:0] C_ST_RESP   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = C_ST_IDLE,
        ST_SETUP  = C_ST_SETUP,
        ST_ACCESS = C_ST_ACCESS,
        ST_RESP   = C_ST_RESP
    } apb_state_e;

    // Read data returned when a transfer is aborted by the wait timer.
    localparam logic [31:0] C_ERR_DATA_DEFAULT = 32'hDEADBEEF;

    // Width of a counter able to hold 0..timeout. A disabled timer (0) still
    // gets one bit so no zero-width vectors are ever declared.
    function automatic int cnt_width(input int timeout);
        if (timeout < 1) begin
            return 1;
        end
        return $clog2(timeout + 1);
    endfunction

endpackage : apb_bridge_pkg
`default_nettype wire

// File: rtl/apb_cmd_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_cmd_bridge_if
// Purpose  : Bundles the command channel, the response channel and the APB3
//            master bus of the bridge.
// Ports    : cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata - command in
//            rsp_valid/rsp_ready/rsp_rdata/rsp_err            - response out
//            psel/penable/pwrite/paddr/pwdata                 - APB request
//            prdata/pready/pslverr                            - APB return
//            modport master : the bridge itself
//            modport slave  : the environment (command source, response
//                             sink and APB slave)
// Revision : 1.0 - initial release
// ============================================================================
interface apb_cmd_bridge_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    // Command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    // Response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    // APB3 bus
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rsp_ready,
        input  prdata, pready, pslverr,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rsp_ready,
        output prdata, pready, pslverr,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata
    );

endinterface : apb_cmd_bridge_if
`default_nettype wire

// File: rtl/apb_cmd_bridge_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : apb_wait_timer
// Purpose  : Counts APB ACCESS cycles spent waiting on pready and flags when
//            the configured limit is reached. A limit of 0 never expires.
// Ports    : pclk      in  - clock
//            prstn     in  - asynchronous active-low reset
//            clear_i   in  - synchronous clear (start of a new transfer)
//            en_i      in  - count one wait cycle
//            expired_o out - counter has reached TIMEOUT
// Revision : 1.0 - initial release
// ============================================================================
module apb_wait_timer
    import apb_bridge_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  wire logic pclk,
    input  wire logic prstn,
    input  wire logic clear_i,
    input  wire logic en_i,
    output logic      expired_o
);

    localparam int W = cnt_width(TIMEOUT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Saturate at the limit so a stalled FSM can never wrap the count.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    generate
        if (TIMEOUT != 0) begin : g_timeout_on
            localparam logic [W-1:0] C_LIMIT = W'(TIMEOUT);
            assign expired_o = (cnt_q == C_LIMIT);
        end else begin : g_timeout_off
            assign expired_o = 1'b0;
        end
    endgenerate

endmodule : apb_wait_timer
`default_nettype wire

// File: rtl/apb_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb_cmd_bridge
// Purpose  : Command-to-APB3 master bridge. Accepts one register read/write
//            command at a time on a valid/ready channel, runs the APB
//            SETUP/ACCESS sequence, and returns read data and status on a
//            valid/ready response channel. Optional wait-state timeout.
// Ports    : pclk  in  - clock
//            prstn in  - asynchronous active-low reset
//            bus   if  - apb_cmd_bridge_if.master (command, response, APB)
// Revision : 1.0 - initial release
// ============================================================================
module apb_cmd_bridge
    import apb_bridge_pkg::*;
#(
    parameter int                ADDR_W   = 12,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 16,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(C_ERR_DATA_DEFAULT)
) (
    input  wire logic         pclk,
    input  wire logic         prstn,
    apb_cmd_bridge_if.master  bus
);

    apb_state_e        state_q,     state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;
    logic              psel_q,      psel_d;
    logic              penable_q,   penable_d;
    logic              pwrite_q,    pwrite_d;
    logic [ADDR_W-1:0] paddr_q,     paddr_d;
    logic [DATA_W-1:0] pwdata_q,    pwdata_d;

    logic w_timer_clr;
    logic w_timer_en;
    logic w_timer_expired;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .pclk      (pclk),
        .prstn     (prstn),
        .clear_i   (w_timer_clr),
        .en_i      (w_timer_en),
        .expired_o (w_timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        w_timer_clr = 1'b0;
        w_timer_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    pwrite_d    = bus.cmd_write;
                    paddr_d     = bus.cmd_addr;
                    pwdata_d    = bus.cmd_wdata;
                    psel_d      = 1'b1;
                    cmd_ready_d = 1'b0;
                    w_timer_clr = 1'b1;
                    state_d     = ST_SETUP;
                end
            end

            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end

            ST_ACCESS: begin
                // A slave completing in the very cycle the limit is reached
                // still wins over the abort.
                if (bus.pready) begin
                    rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
                    rsp_err_d   = bus.pslverr;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (w_timer_expired) begin
                    rsp_rdata_d = pwrite_q ? '0 : ERR_DATA;
                    rsp_err_d   = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    w_timer_en = 1'b1;
                end
            end

            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;

endmodule : apb_cmd_bridge
`default_nettype wire

// File: tb/tb_apb_cmd_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_cmd_bridge
// Purpose  : Self-checking bench for apb_cmd_bridge. Provides a small
//            registered-prdata regmap slave (0x300/0x304/0x308) with
//            programmable wait states and slave error, a transaction-level
//            expectation model, and directed command sequences.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_cmd_bridge;

    localparam int          ADDR_W  = 12;
    localparam int          DATA_W  = 32;
    localparam int          TIMEOUT = 16;
    localparam logic [31:0] C_ERR   = 32'hDEADBEEF;
    localparam logic [31:0] C_UNMAP = 32'hDEADBEEF;

    logic pclk = 1'b0;
    logic prstn;

    apb_cmd_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_cmd_bridge #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .TIMEOUT  (TIMEOUT),
        .ERR_DATA (C_ERR)
    ) dut (
        .pclk  (pclk),
        .prstn (prstn),
        .bus   (bus)
    );

    always #5 pclk = ~pclk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Regmap slave: prdata registered at the SETUP->ACCESS edge, pready
    // held low for cfg_wait ACCESS cycles, no write on slave error.
    // ------------------------------------------------------------------
    int   cfg_wait   = 0;
    logic cfg_slverr = 1'b0;
    int   acc_cnt    = 0;
    logic [31:0] slv_mem [3] = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0010};

    function automatic bit is_mapped(input logic [11:0] a);
        return (a >= 12'h300) && (a <= 12'h308) && (a[1:0] == 2'b00);
    endfunction

    function automatic int reg_idx(input logic [11:0] a);
        logic [11:0] off;
        off = a - 12'h300;
        return int'(off >> 2);
    endfunction

    always @(posedge pclk) begin
        if (bus.psel && !bus.penable)
            bus.prdata <= is_mapped(bus.paddr) ? slv_mem[reg_idx(bus.paddr)] : C_UNMAP;
        if (bus.psel && bus.penable && bus.pready && bus.pwrite && !bus.pslverr && is_mapped(bus.paddr))
            slv_mem[reg_idx(bus.paddr)] <= bus.pwdata;
        acc_cnt <= (bus.psel && bus.penable) ? acc_cnt + 1 : 0;
    end

    assign bus.pready  = (acc_cnt >= cfg_wait);
    assign bus.pslverr = cfg_slverr;

    // ------------------------------------------------------------------
    // Transaction-level model: once a command is accepted, k counts cycles
    // since acceptance; with w effective wait cycles, SETUP is k=1, ACCESS
    // spans k=2..2+w and the response appears from k=3+w until handshake.
    // ------------------------------------------------------------------
    bit          m_busy     = 1'b0;
    int          m_k        = 0;
    int          m_w        = 0;
    logic [11:0] m_paddr    = '0;
    logic        m_pwrite   = 1'b0;
    logic [31:0] m_pwdata   = '0;
    logic [31:0] m_exp_data = '0;
    logic        m_exp_err  = 1'b0;
    logic [31:0] m_mem [3]  = '{32'h0000_0000, 32'h1234_5678, 32'h0000_0010};

    always @(negedge pclk) begin : p_compare
        bit e_psel;
        bit e_pen;
        bit e_rv;
        bit to;
        if (!prstn) begin
            m_busy   = 1'b0;
            m_paddr  = '0;
            m_pwrite = 1'b0;
            m_pwdata = '0;
            chk1("rst_cmd_ready", bus.cmd_ready, 1'b1);
            chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
            chk ("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
            chk1("rst_rsp_err",   bus.rsp_err,   1'b0);
            chk1("rst_psel",      bus.psel,      1'b0);
            chk1("rst_penable",   bus.penable,   1'b0);
            chk1("rst_pwrite",    bus.pwrite,    1'b0);
            chk ("rst_paddr",     32'(bus.paddr), 32'h0);
            chk ("rst_pwdata",    bus.pwdata,    32'h0);
        end else begin
            if (m_busy) m_k++;
            e_psel = m_busy && (m_k <= 2 + m_w);
            e_pen  = m_busy && (m_k >= 2) && (m_k <= 2 + m_w);
            e_rv   = m_busy && (m_k >= 3 + m_w);
            chk1("m_cmd_ready", bus.cmd_ready, !m_busy);
            chk1("m_psel",      bus.psel,      e_psel);
            chk1("m_penable",   bus.penable,   e_pen);
            chk1("m_pen_wo_sel", bus.penable & ~bus.psel, 1'b0);
            chk1("m_rsp_valid", bus.rsp_valid, e_rv);
            chk ("m_paddr",     32'(bus.paddr), 32'(m_paddr));
            chk1("m_pwrite",    bus.pwrite,    m_pwrite);
            chk ("m_pwdata",    bus.pwdata,    m_pwdata);
            if (e_rv) begin
                chk ("m_rsp_rdata", bus.rsp_rdata, m_exp_data);
                chk1("m_rsp_err",   bus.rsp_err,   m_exp_err);
            end
            if (!m_busy) begin
                if (bus.cmd_valid === 1'b1) begin
                    m_busy   = 1'b1;
                    m_k      = 0;
                    m_paddr  = bus.cmd_addr;
                    m_pwrite = bus.cmd_write;
                    m_pwdata = bus.cmd_wdata;
                    to       = (TIMEOUT != 0) && (cfg_wait > TIMEOUT);
                    m_w      = to ? TIMEOUT : cfg_wait;
                    if (bus.cmd_write) begin
                        m_exp_data = 32'h0;
                        if (!to && !cfg_slverr && is_mapped(bus.cmd_addr))
                            m_mem[reg_idx(bus.cmd_addr)] = bus.cmd_wdata;
                    end else if (to) begin
                        m_exp_data = C_ERR;
                    end else begin
                        m_exp_data = is_mapped(bus.cmd_addr) ? m_mem[reg_idx(bus.cmd_addr)] : C_UNMAP;
                    end
                    m_exp_err = to || cfg_slverr;
                end
            end else if (e_rv && bus.rsp_ready === 1'b1) begin
                m_busy = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // One command: called at the start of a cycle (posedge + 1). rdelay = 0
    // keeps rsp_ready high; otherwise the response is held off for rdelay
    // cycles while a junk command is presented upstream.
    // ------------------------------------------------------------------
    task automatic do_cmd(input string tag, input logic wr, input logic [11:0] addr,
                          input logic [31:0] wdata, input int nwait, input logic slverr,
                          input int rdelay, input int exp_lat, input logic [31:0] exp_data,
                          input logic exp_err, output int acc_cyc);
        int n;
        int lat;
        cfg_wait      = nwait;
        cfg_slverr    = slverr;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.rsp_ready = (rdelay == 0);
        n = 0;
        @(negedge pclk);
        while (bus.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge pclk);
            n++;
        end
        chk1({tag, "_accept"}, bus.cmd_ready, 1'b1);
        acc_cyc = cyc;
        @(posedge pclk);
        #1;
        bus.cmd_valid = (rdelay > 0);
        bus.cmd_write = ~wr;
        bus.cmd_addr  = 12'hFFF;
        bus.cmd_wdata = 32'h5555_AAAA;
        lat = 0;
        do begin
            @(negedge pclk);
            lat++;
            if (lat == 1) begin
                chk1({tag, "_setup_psel"},    bus.psel,    1'b1);
                chk1({tag, "_setup_penable"}, bus.penable, 1'b0);
                chk ({tag, "_setup_paddr"},   32'(bus.paddr), 32'(addr));
                chk1({tag, "_setup_pwrite"},  bus.pwrite,  wr);
            end
        end while (bus.rsp_valid !== 1'b1 && lat < 200);
        chk ({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk ({tag, "_rdata"},   bus.rsp_rdata, exp_data);
        chk1({tag, "_err"},     bus.rsp_err,   exp_err);
        chk1({tag, "_resp_psel"}, bus.psel,    1'b0);
        if (rdelay > 0) begin
            repeat (rdelay) @(posedge pclk);
            #1;
            chk1({tag, "_held_valid"}, bus.rsp_valid, 1'b1);
            chk ({tag, "_held_rdata"}, bus.rsp_rdata, exp_data);
            chk1({tag, "_held_cmd_ready"}, bus.cmd_ready, 1'b0);
            bus.rsp_ready = 1'b1;
            bus.cmd_valid = 1'b0;
        end
        @(posedge pclk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int a0;
        int a1;
        int a2;
        prstn         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(posedge pclk);
        #1;
        chk1("reset_cmd_ready", bus.cmd_ready, 1'b1);
        chk1("reset_psel",      bus.psel,      1'b0);
        chk1("reset_rsp_valid", bus.rsp_valid, 1'b0);
        prstn = 1'b1;
        @(posedge pclk);
        #1;

        do_cmd("wr300",     1'b1, 12'h300, 32'hABCD_1234, 0,    1'b0, 0, 3,  32'h0,         1'b0, a0);
        do_cmd("rd308",     1'b0, 12'h308, 32'h0,         0,    1'b0, 0, 3,  32'h0000_0010, 1'b0, a0);
        do_cmd("rd30c",     1'b0, 12'h30C, 32'h0,         0,    1'b0, 0, 3,  32'hDEAD_BEEF, 1'b0, a0);
        do_cmd("rd300",     1'b0, 12'h300, 32'h0,         0,    1'b0, 0, 3,  32'hABCD_1234, 1'b0, a0);
        do_cmd("wr304_err", 1'b1, 12'h304, 32'h0BAD_F00D, 3,    1'b1, 0, 6,  32'h0,         1'b1, a0);
        do_cmd("rd304",     1'b0, 12'h304, 32'h0,         0,    1'b0, 0, 3,  32'h1234_5678, 1'b0, a0);
        do_cmd("rd_tmo",    1'b0, 12'h308, 32'h0,         1000, 1'b0, 0, 19, 32'hDEAD_BEEF, 1'b1, a0);
        do_cmd("wr_tmo",    1'b1, 12'h300, 32'h0000_0001, 1000, 1'b0, 0, 19, 32'h0,         1'b1, a0);
        do_cmd("rd_w16",    1'b0, 12'h308, 32'h0,         16,   1'b0, 0, 19, 32'h0000_0010, 1'b0, a0);
        do_cmd("rd_bp",     1'b0, 12'h308, 32'h0,         0,    1'b0, 5, 3,  32'h0000_0010, 1'b0, a0);

        do_cmd("b2b0",      1'b1, 12'h304, 32'h1111_1111, 0,    1'b0, 0, 3,  32'h0,         1'b0, a0);
        do_cmd("b2b1",      1'b1, 12'h308, 32'h2222_2222, 0,    1'b0, 0, 3,  32'h0,         1'b0, a1);
        do_cmd("b2b2",      1'b0, 12'h304, 32'h0,         0,    1'b0, 0, 3,  32'h1111_1111, 1'b0, a2);
        chk("b2b_period_01", 32'(a1 - a0), 32'd4);
        chk("b2b_period_12", 32'(a2 - a1), 32'd4);

        // Reset while the slave stalls in ACCESS.
        cfg_wait      = 1000;
        cfg_slverr    = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 12'h308;
        @(posedge pclk);
        #1;
        bus.cmd_valid = 1'b0;
        @(posedge pclk);
        #1;
        chk1("midrst_pre_psel",    bus.psel,    1'b1);
        chk1("midrst_pre_penable", bus.penable, 1'b1);
        prstn = 1'b0;
        #1;
        chk1("midrst_psel",      bus.psel,      1'b0);
        chk1("midrst_penable",   bus.penable,   1'b0);
        chk1("midrst_cmd_ready", bus.cmd_ready, 1'b1);
        repeat (2) @(posedge pclk);
        #1;
        prstn = 1'b1;
        repeat (4) begin
            @(negedge pclk);
            chk1("midrst_no_rsp", bus.rsp_valid, 1'b0);
        end
        @(posedge pclk);
        #1;
        do_cmd("rd_after_rst", 1'b0, 12'h308, 32'h0, 0, 1'b0, 0, 3, 32'h2222_2222, 1'b0, a0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_apb_cmd_bridge
`default_nettype wire
